bitwise_logic_pipe: RTL and testbench

Parametrised, pipelined bitwise logic unit: the generalised successor of the single-bit inverter. It performs one of eight bitwise operations on WIDTH-bit operands, registered through a STAGES-deep elastic pipeline with valid/ready handshakes on both sides. It sits between operand producers and result consumers in datapath designs, and it also reports a zero flag and a completed-transaction count.

---
 rtl/bitwise_logic_pipe.sv | 101 ++++++++++
 tb/tb_bitwise_logic_pipe.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/bitwise_logic_pipe.sv
// Purpose    : eight-way bitwise logic unit (NOT/AND/OR/XOR, their inversions, pass-through) feeding an elastic pipeline.
// Latency    : STAGES cycles from presentation to out_valid; one result per cycle sustained.
// Backpressure: ready ripples back stage by stage, so in_ready drops only when every stage is full and out_ready is low.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready input handshake; op, a, b are sampled on acceptance
//   out_valid/out_ready output handshake; out and zero are registered
//   txn_count         completed output handshakes, wraps at 16 bits
module bitwise_logic_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic [15:0]      txn_count
);

    localparam logic [STAGES-1:0] ALL_ONES = {STAGES{1'b1}};

    logic [WIDTH-1:0]  res;
    logic              res_zero;
    logic [WIDTH-1:0]  dat_q [STAGES];
    logic [STAGES-1:0] zr_q;
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] rdy;

    // Operation decode; b is unused for op 000 and op 111.
    always_comb begin
        res = '0;
        case (op)
            3'b000: res = ~a;
            3'b001: res = a & b;
            3'b010: res = a | b;
            3'b011: res = a ^ b;
            3'b100: res = ~(a & b);
            3'b101: res = ~(a | b);
            3'b110: res = ~(a ^ b);
            3'b111: res = a;
            default: res = '0;
        endcase
        res_zero = (res == '0);
    end

    // Stage k can load when any stage at or downstream of k is empty, or
    // the consumer takes the result. Written as a masked OR rather than a
    // recursive chain so each bit depends only on v_q and out_ready.
    always_comb begin
        rdy = '0;
        for (int k = 0; k < STAGES; k++) begin
            rdy[k] = out_ready || ((~v_q & (ALL_ONES << k)) != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q       <= '0;
            zr_q      <= '0;
            txn_count <= '0;
            for (int k = 0; k < STAGES; k++) begin
                dat_q[k] <= '0;
            end
        end else begin
            // Stage 0: valid follows in_valid whenever it can load; data is
            // only written on a real acceptance so bubbles keep old data.
            if (rdy[0]) begin
                v_q[0] <= in_valid;
                if (in_valid) begin
                    dat_q[0] <= res;
                    zr_q[0]  <= res_zero;
                end
            end
            // Later stages shift whenever they can load, bubble or not.
            for (int k = 1; k < STAGES; k++) begin
                if (rdy[k]) begin
                    v_q[k]   <= v_q[k-1];
                    dat_q[k] <= dat_q[k-1];
                    zr_q[k]  <= zr_q[k-1];
                end
            end
            if (v_q[STAGES-1] && out_ready) begin
                txn_count <= txn_count + 16'd1;
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v_q[STAGES-1];
    assign out       = dat_q[STAGES-1];
    assign zero      = zr_q[STAGES-1];

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Purpose    : directed self-checking bench for bitwise_logic_pipe across four parameter sets.
// Latency    : expected values are hand-computed and checked cycle by cycle.
// Backpressure: exercised through the shared out_ready driven by the bench.
module tb_bitwise_logic_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        out_ready;
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        iv8, iv4, iv1, iv64;

    logic        ir8, ov8, z8;
    logic [7:0]  out8;
    logic [15:0] txn8;
    logic        ir4, ov4, z4;
    logic [7:0]  out4;
    logic [15:0] txn4;
    logic        ir1, ov1, z1;
    logic [0:0]  out1;
    logic [15:0] txn1;
    logic        ir64, ov64, z64;
    logic [63:0] out64;
    logic [15:0] txn64;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bitwise_logic_pipe #(.WIDTH(8), .STAGES(2)) u8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .op(op),
        .a(a[7:0]), .b(b[7:0]), .out_valid(ov8), .out_ready(out_ready),
        .out(out8), .zero(z8), .txn_count(txn8));

    bitwise_logic_pipe #(.WIDTH(8), .STAGES(4)) u4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .op(op),
        .a(a[7:0]), .b(b[7:0]), .out_valid(ov4), .out_ready(out_ready),
        .out(out4), .zero(z4), .txn_count(txn4));

    bitwise_logic_pipe #(.WIDTH(1), .STAGES(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .op(op),
        .a(a[0:0]), .b(b[0:0]), .out_valid(ov1), .out_ready(out_ready),
        .out(out1), .zero(z1), .txn_count(txn1));

    bitwise_logic_pipe #(.WIDTH(64), .STAGES(1)) u64 (
        .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .op(op),
        .a(a), .b(b), .out_valid(ov64), .out_ready(out_ready),
        .out(out64), .zero(z64), .txn_count(txn64));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // a = A5, b = 0F through ops 000..111
    logic [7:0]  exp8  [8] = '{8'h5A, 8'h05, 8'hAF, 8'hAA, 8'hFA, 8'h50, 8'h55, 8'hA5};
    // a = 1, b = 0
    logic        exp1  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    // a = 0, b = F0F0_0000_FFFF_1234
    logic [63:0] exp64 [8] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
                               64'hF0F0_0000_FFFF_1234, 64'hF0F0_0000_FFFF_1234,
                               64'hFFFF_FFFF_FFFF_FFFF, 64'h0F0F_FFFF_0000_EDCB,
                               64'h0F0F_FFFF_0000_EDCB, 64'h0};

    initial begin
        rst = 1'b1; out_ready = 1'b1; op = 3'd0; a = '0; b = '0;
        iv8 = 1'b0; iv4 = 1'b0; iv1 = 1'b0; iv64 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_out", out8, 0);
        chk("rst_ov", ov8, 0);
        chk("rst_ir", ir8, 1);
        chk("rst_txn", txn8, 0);
        chk("rst_ov4", ov4, 0);

        // op sweep, back to back, out_ready high
        for (int i = 0; i < 10; i++) begin
            if (i < 8) begin
                iv8 = 1'b1; a = 64'hA5; b = 64'h0F; op = 3'(i);
            end else begin
                iv8 = 1'b0;
            end
            tick();
            if (i == 0) chk("lat_ov", ov8, 0);
            if (i >= 1 && i <= 8) begin
                chk($sformatf("op%0d_ov", i-1), ov8, 1);
                chk($sformatf("op%0d_out", i-1), out8, exp8[i-1]);
            end
        end
        chk("sweep_txn", txn8, 8);
        chk("sweep_ov_end", ov8, 0);

        // zero flag
        iv8 = 1'b1; a = 64'hFF; op = 3'b000;
        tick();
        a = 64'h3C; b = 64'hC3; op = 3'b001;
        tick();
        iv8 = 1'b0;
        chk("z0_out", out8, 0);
        chk("z0_zero", z8, 1);
        chk("z0_ov", ov8, 1);
        tick();
        chk("z1_out", out8, 0);
        chk("z1_zero", z8, 1);
        chk("z1_ov", ov8, 1);
        tick();
        chk("z_txn", txn8, 10);

        // backpressure, STAGES = 2
        out_ready = 1'b0; op = 3'b111; iv8 = 1'b1; a = 64'h11;
        #1 chk("bp_ir0", ir8, 1);
        tick();
        a = 64'h22;
        #1 chk("bp_ir1", ir8, 1);
        tick();
        a = 64'h33;
        #1 chk("bp_ir_full", ir8, 0);
        chk("bp_out_a", out8, 8'h11);
        chk("bp_ov_a", ov8, 1);
        tick();
        chk("bp_out_b", out8, 8'h11);
        chk("bp_ir_b", ir8, 0);
        tick();
        chk("bp_out_c", out8, 8'h11);
        out_ready = 1'b1;
        #1 chk("bp_ir_comb", ir8, 1);
        tick();
        iv8 = 1'b0;
        chk("bp_res2", out8, 8'h22);
        chk("bp_ov2", ov8, 1);
        tick();
        chk("bp_res3", out8, 8'h33);
        chk("bp_ov3", ov8, 1);
        tick();
        chk("bp_ov_end", ov8, 0);
        chk("bp_txn", txn8, 13);

        // reset with two results in flight
        out_ready = 1'b0; iv8 = 1'b1; a = 64'h44;
        tick();
        a = 64'h55;
        tick();
        rst = 1'b1; a = 64'h66; out_ready = 1'b1;
        tick();
        rst = 1'b0; iv8 = 1'b0;
        #1;
        chk("mr_ov", ov8, 0);
        chk("mr_txn", txn8, 0);
        chk("mr_ir", ir8, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("mr_flush%0d", i), ov8, 0);
        end
        chk("mr_txn_after", txn8, 0);

        // 65537 transactions wrap the counter to 1
        op = 3'b111; a = '0; out_ready = 1'b1; iv8 = 1'b1;
        for (int i = 0; i < 65537; i++) tick();
        iv8 = 1'b0;
        tick();
        tick();
        chk("wrap_txn", txn8, 16'h0001);
        chk("wrap_ov", ov8, 0);

        // STAGES = 4: fill, then 10 cycles of overlapped in/out
        out_ready = 1'b0; op = 3'b111; iv4 = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            a = 64'(i);
            tick();
        end
        a = 64'd5;
        #1;
        chk("s4_full_ir", ir4, 0);
        chk("s4_full_out", out4, 1);
        chk("s4_full_ov", ov4, 1);
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            a = 64'(5 + c);
            #1;
            chk($sformatf("s4_ir%0d", c), ir4, 1);
            chk($sformatf("s4_ov%0d", c), ov4, 1);
            chk($sformatf("s4_out%0d", c), out4, 64'(c + 1));
            tick();
        end
        iv4 = 1'b0;
        chk("s4_txn", txn4, 10);
        chk("s4_next", out4, 11);

        // WIDTH = 1, STAGES = 1 sweep
        iv1 = 1'b1; a = 64'd1; b = 64'd0; op = 3'd0;
        #1 chk("w1_lat_ov", ov1, 0);
        for (int i = 0; i < 8; i++) begin
            op = 3'(i);
            tick();
            chk($sformatf("w1_ov%0d", i), ov1, 1);
            chk($sformatf("w1_op%0d", i), out1, exp1[i]);
        end
        a = 64'd0; op = 3'b000;
        tick();
        iv1 = 1'b0;
        chk("w1_not0", out1, 1);
        chk("w1_not0_z", z1, 0);

        // WIDTH = 64, STAGES = 1 sweep
        iv64 = 1'b1; a = 64'd0; b = 64'hF0F0_0000_FFFF_1234; op = 3'd0;
        #1 chk("w64_lat_ov", ov64, 0);
        for (int i = 0; i < 8; i++) begin
            op = 3'(i);
            tick();
            chk($sformatf("w64_ov%0d", i), ov64, 1);
            chk($sformatf("w64_op%0d", i), out64, exp64[i]);
            chk($sformatf("w64_z%0d", i), z64, 64'(exp64[i] == 64'h0));
        end
        iv64 = 1'b0;
        tick();
        chk("w64_txn", txn64, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
